// File: rtl/gain_ramp_controller_pkg.sv
// Shared definitions for the gain ramp controller and the filter-bank amplifier:
// handshake state encoding, gain range helpers and packed-vector slicing.
package gain_ramp_controller_pkg;

    typedef enum logic [0:0] {
        HS_IDLE   = 1'b0,
        HS_COMMIT = 1'b1
    } hs_state_e;

    function automatic int unity_gain(input int frac_bits);
        return 32'sd1 << frac_bits;
    endfunction

    function automatic int gain_max(input int gain_bits);
        return (32'sd1 << (gain_bits - 32'sd1)) - 32'sd1;
    endfunction

    function automatic int gain_min(input int gain_bits);
        return -(32'sd1 << (gain_bits - 32'sd1));
    endfunction

    // LSB position of channel ch inside a packed gain vector
    function automatic int gain_lsb(input int ch, input int gain_bits);
        return ch * gain_bits;
    endfunction

endpackage

// File: rtl/gain_ramp_channel.sv
// One channel of the gain ramp: holds target and applied gain, steps applied one
// LSB toward target on each tick and reports equality of the next state.
module gain_ramp_channel
    import gain_ramp_controller_pkg::*;
#(
    parameter int GAIN_BITS      = 2,
    parameter int GAIN_FRAC_BITS = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 commit_we,
    input  logic [GAIN_BITS-1:0] commit_gain,
    input  logic                 tick,
    output logic [GAIN_BITS-1:0] applied,
    output logic                 equal_next
);

    localparam logic [GAIN_BITS-1:0] UNITY_C = GAIN_BITS'(unity_gain(GAIN_FRAC_BITS));
    localparam logic [GAIN_BITS-1:0] ONE_C   = {{(GAIN_BITS-1){1'b0}}, 1'b1};

    logic [GAIN_BITS-1:0] target_r;
    logic [GAIN_BITS-1:0] applied_r;
    logic [GAIN_BITS-1:0] target_nxt_s;
    logic [GAIN_BITS-1:0] applied_nxt_s;

    // Next-state: the step compares against the pre-commit target, so a commit in
    // a tick cycle only takes effect from the following tick.
    always_comb begin
        target_nxt_s  = target_r;
        applied_nxt_s = applied_r;
        if (commit_we) begin
            target_nxt_s = commit_gain;
        end else begin
            target_nxt_s = target_r;
        end
        if (tick) begin
            if ($signed(applied_r) < $signed(target_r)) begin
                applied_nxt_s = applied_r + ONE_C;
            end else if ($signed(applied_r) > $signed(target_r)) begin
                applied_nxt_s = applied_r - ONE_C;
            end else begin
                applied_nxt_s = applied_r;
            end
        end else begin
            applied_nxt_s = applied_r;
        end
        equal_next = (applied_nxt_s == target_nxt_s);
    end

    // Target and applied gain registers
    always_ff @(posedge clk) begin
        if (rst) begin
            target_r  <= UNITY_C;
            applied_r <= UNITY_C;
        end else begin
            target_r  <= target_nxt_s;
            applied_r <= applied_nxt_s;
        end
    end

    assign applied = applied_r;

endmodule

// File: rtl/gain_ramp_controller.sv
// Accepts gain/enable writes over valid/ready, commits them to per-channel targets
// and drives the ramped gain vector, amplifier enable and settled flag.
module gain_ramp_controller
    import gain_ramp_controller_pkg::*;
#(
    parameter int NUMBER_OF_FILTERS = 8,
    parameter int GAIN_BITS         = 2,
    parameter int GAIN_FRAC_BITS    = 0,
    parameter int CH_BITS           = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   sample_tick,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic                                   cfg_all,
    input  logic [CH_BITS-1:0]                     cfg_ch,
    input  logic [GAIN_BITS-1:0]                   cfg_gain,
    input  logic                                   cfg_en,
    output logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] gains,
    output logic                                   amp_en,
    output logic                                   settled
);

    hs_state_e                    state_r;
    logic                         cfg_ready_r;
    logic                         pend_all_r;
    logic                         pend_en_r;
    logic [CH_BITS-1:0]           pend_ch_r;
    logic [GAIN_BITS-1:0]         pend_gain_r;
    logic                         amp_en_req_r;
    logic                         amp_en_r;
    logic                         settled_r;
    logic                         accept_s;
    logic                         commit_s;
    logic [NUMBER_OF_FILTERS-1:0] commit_we_s;
    logic [NUMBER_OF_FILTERS-1:0] equal_next_s;

    assign accept_s = cfg_valid & cfg_ready_r;
    assign commit_s = (state_r == HS_COMMIT);

    // Commit write-enable decode; an out-of-range channel matches nothing
    always_comb begin
        commit_we_s = '0;
        for (int i = 0; i < NUMBER_OF_FILTERS; i++) begin
            if (commit_s && (pend_all_r || (pend_ch_r == CH_BITS'(i)))) begin
                commit_we_s[i] = 1'b1;
            end else begin
                commit_we_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUMBER_OF_FILTERS; g++) begin : g_ch
        localparam int LSB = gain_lsb(g, GAIN_BITS);
        gain_ramp_channel #(
            .GAIN_BITS     (GAIN_BITS),
            .GAIN_FRAC_BITS(GAIN_FRAC_BITS)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .commit_we  (commit_we_s[g]),
            .commit_gain(pend_gain_r),
            .tick       (sample_tick),
            .applied    (gains[LSB +: GAIN_BITS]),
            .equal_next (equal_next_s[g])
        );
    end

    // Handshake FSM, pending request, enable sequencing and settled flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= HS_IDLE;
            cfg_ready_r  <= 1'b1;
            pend_all_r   <= 1'b0;
            pend_en_r    <= 1'b0;
            pend_ch_r    <= '0;
            pend_gain_r  <= '0;
            amp_en_req_r <= 1'b0;
            amp_en_r     <= 1'b0;
            settled_r    <= 1'b1;
        end else begin
            case (state_r)
                HS_IDLE: begin
                    if (accept_s) begin
                        pend_all_r  <= cfg_all;
                        pend_en_r   <= cfg_en;
                        pend_ch_r   <= cfg_ch;
                        pend_gain_r <= cfg_gain;
                        state_r     <= HS_COMMIT;
                        cfg_ready_r <= 1'b0;
                    end else begin
                        state_r     <= HS_IDLE;
                        cfg_ready_r <= 1'b1;
                    end
                end
                HS_COMMIT: begin
                    amp_en_req_r <= pend_en_r;
                    state_r      <= HS_IDLE;
                    cfg_ready_r  <= 1'b1;
                end
                default: begin
                    state_r     <= HS_IDLE;
                    cfg_ready_r <= 1'b1;
                end
            endcase
            // Enable moves only on a sample boundary, using the pre-commit request
            if (sample_tick) begin
                amp_en_r <= amp_en_req_r;
            end else begin
                amp_en_r <= amp_en_r;
            end
            settled_r <= &equal_next_s;
        end
    end

    assign cfg_ready = cfg_ready_r;
    assign amp_en    = amp_en_r;
    assign settled   = settled_r;

endmodule

// File: tb/tb_gain_ramp_controller.sv
// Self-checking bench for gain_ramp_controller: directed scenarios plus a random
// run, all compared against an integer-level behavioural model.
module tb_gain_ramp_controller;

    localparam int N  = 8;
    localparam int GB = 2;
    localparam int GF = 0;
    localparam int CB = 4;  // wide enough to address channels beyond the bank

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              sample_tick = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic              cfg_all = 1'b0;
    logic [CB-1:0]     cfg_ch = '0;
    logic [GB-1:0]     cfg_gain = '0;
    logic              cfg_en = 1'b0;
    logic [N*GB-1:0]   gains;
    logic              amp_en;
    logic              settled;

    gain_ramp_controller #(
        .NUMBER_OF_FILTERS(N),
        .GAIN_BITS        (GB),
        .GAIN_FRAC_BITS   (GF),
        .CH_BITS          (CB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_tick(sample_tick),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_all    (cfg_all),
        .cfg_ch     (cfg_ch),
        .cfg_gain   (cfg_gain),
        .cfg_en     (cfg_en),
        .gains      (gains),
        .amp_en     (amp_en),
        .settled    (settled)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model state (plain integers)
    int m_tgt[N];
    int m_app[N];
    bit m_en_req, m_en, m_pend, m_pall, m_pen, m_ready, m_settled;
    int m_pch, m_pgain;

    function automatic int to_int(input logic [GB-1:0] g);
        return int'($signed(g));
    endfunction

    function automatic logic [N*GB-1:0] model_gains();
        logic [N*GB-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*GB +: GB] = GB'(m_app[i]);
        return r;
    endfunction

    // Advance model and DUT by one clock; outputs are sampled 1ns after the edge
    task automatic clk_cycle();
        bit acc;
        acc = cfg_valid && m_ready;
        if (rst) begin
            for (int i = 0; i < N; i++) begin m_tgt[i] = 1 << GF; m_app[i] = 1 << GF; end
            m_en_req = 1'b0; m_en = 1'b0; m_pend = 1'b0; m_ready = 1'b1;
        end else begin
            if (sample_tick) begin
                for (int i = 0; i < N; i++) begin
                    if (m_app[i] < m_tgt[i]) m_app[i] = m_app[i] + 1;
                    else if (m_app[i] > m_tgt[i]) m_app[i] = m_app[i] - 1;
                end
                m_en = m_en_req;
            end
            if (m_pend) begin
                for (int i = 0; i < N; i++) if (m_pall || m_pch == i) m_tgt[i] = m_pgain;
                m_en_req = m_pen;
                m_pend = 1'b0;
            end
            if (acc) begin
                m_pall = cfg_all; m_pch = int'(cfg_ch); m_pgain = to_int(cfg_gain);
                m_pen = cfg_en; m_pend = 1'b1;
            end
            m_ready = !m_pend;
        end
        m_settled = 1'b1;
        for (int i = 0; i < N; i++) if (m_app[i] != m_tgt[i]) m_settled = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_cycle(); rst = 1'b0;
        vectors += 4;
        if (gains !== 16'h5555) begin miscompares++; $display("FAIL reset_gains: got %h expected 5555", gains); end
        if (amp_en !== 1'b0) begin miscompares++; $display("FAIL reset_amp_en: got %b expected 0", amp_en); end
        if (settled !== 1'b1) begin miscompares++; $display("FAIL reset_settled: got %b expected 1", settled); end
        if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", cfg_ready); end
        for (int k = 0; k < 10; k++) begin
            sample_tick = 1'b1; clk_cycle(); sample_tick = 1'b0; clk_cycle();
            vectors++;
            if (gains !== 16'h5555 || settled !== 1'b1) begin
                miscompares++; $display("FAIL idle_ticks: got gains=%h settled=%b expected 5555/1", gains, settled);
            end
        end
    endtask

    task automatic test_single_write();
        int exp3[3] = '{0, -1, -2};
        logic [N*GB-1:0] eg;
        cfg_valid = 1'b1; cfg_all = 1'b0; cfg_ch = 4'd3; cfg_gain = 2'b10; cfg_en = 1'b1;
        clk_cycle(); cfg_valid = 1'b0;
        vectors++;
        if (cfg_ready !== 1'b0) begin miscompares++; $display("FAIL ready_after_accept: got %b expected 0", cfg_ready); end
        clk_cycle();
        vectors += 2;
        if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_commit: got %b expected 1", cfg_ready); end
        if (settled !== 1'b0) begin miscompares++; $display("FAIL settled_after_commit: got %b expected 0", settled); end
        for (int k = 0; k < 3; k++) begin
            sample_tick = 1'b1; clk_cycle(); sample_tick = 1'b0;
            eg = 16'h5555; eg[7:6] = GB'(exp3[k]);
            vectors += 3;
            if (gains !== eg) begin miscompares++; $display("FAIL ch3_ramp: tick %0d got %h expected %h", k + 1, gains, eg); end
            if (settled !== (k == 2)) begin miscompares++; $display("FAIL ch3_settled: tick %0d got %b expected %b", k + 1, settled, k == 2); end
            if (amp_en !== 1'b1) begin miscompares++; $display("FAIL ch3_amp_en: tick %0d got %b expected 1", k + 1, amp_en); end
            clk_cycle();
        end
    endtask

    task automatic test_all_write();
        rst = 1'b1; clk_cycle(); rst = 1'b0;
        cfg_valid = 1'b1; cfg_all = 1'b1; cfg_ch = CB'($urandom_range(0, 15)); cfg_gain = 2'b00; cfg_en = 1'b1;
        clk_cycle(); cfg_valid = 1'b0; clk_cycle();
        vectors++;
        if (settled !== 1'b0) begin miscompares++; $display("FAIL all_settled_pre: got %b expected 0", settled); end
        sample_tick = 1'b1; clk_cycle(); sample_tick = 1'b0;
        vectors += 3;
        if (gains !== 16'h0000 || gains !== model_gains()) begin
            miscompares++; $display("FAIL all_gains: got %h expected 0000", gains);
        end
        if (settled !== 1'b1) begin miscompares++; $display("FAIL all_settled: got %b expected 1", settled); end
        if (amp_en !== 1'b1) begin miscompares++; $display("FAIL all_amp_en: got %b expected 1", amp_en); end
    endtask

    task automatic test_same_cycle();
        cfg_valid = 1'b1; cfg_all = 1'b0; cfg_ch = 4'd5; cfg_gain = 2'b01; cfg_en = 1'b1;
        clk_cycle(); cfg_valid = 1'b0;
        sample_tick = 1'b1; clk_cycle(); sample_tick = 1'b0;
        vectors += 2;
        if (gains !== 16'h0000) begin miscompares++; $display("FAIL same_cycle_no_step: got %h expected 0000", gains); end
        if (settled !== 1'b0) begin miscompares++; $display("FAIL same_cycle_settled: got %b expected 0", settled); end
        clk_cycle();
        sample_tick = 1'b1; clk_cycle(); sample_tick = 1'b0;
        vectors += 2;
        if (gains !== 16'h0400) begin miscompares++; $display("FAIL same_cycle_step: got %h expected 0400", gains); end
        if (settled !== 1'b1) begin miscompares++; $display("FAIL same_cycle_settled2: got %b expected 1", settled); end
    endtask

    task automatic test_back_to_back();
        logic prev_ready;
        logic [GB-1:0] last_gain;
        int exp0[3] = '{-1, 0, 1};
        last_gain = '0;
        cfg_valid = 1'b1; cfg_all = 1'b0; cfg_ch = 4'd2;
        for (int k = 0; k < 10; k++) begin
            cfg_gain = GB'($urandom); cfg_en = 1'(k);
            prev_ready = cfg_ready;
            if (prev_ready) last_gain = cfg_gain;
            clk_cycle();
            vectors += 2;
            if (cfg_ready !== !prev_ready) begin miscompares++; $display("FAIL b2b_alternate: cycle %0d got %b expected %b", k, cfg_ready, !prev_ready); end
            if (gains !== model_gains()) begin miscompares++; $display("FAIL b2b_gains: cycle %0d got %h expected %h", k, gains, model_gains()); end
        end
        cfg_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin sample_tick = 1'b1; clk_cycle(); sample_tick = 1'b0; clk_cycle(); end
        vectors++;
        if (gains[5:4] !== last_gain || settled !== 1'b1) begin
            miscompares++; $display("FAIL b2b_last_wins: got ch2=%b settled=%b expected %b/1", gains[5:4], settled, last_gain);
        end
        // ch0 heads for -2, then is retargeted to +1 after one step
        cfg_valid = 1'b1; cfg_ch = 4'd0; cfg_gain = 2'b10; cfg_en = 1'b1;
        clk_cycle(); cfg_valid = 1'b0; clk_cycle();
        for (int k = 0; k < 3; k++) begin
            sample_tick = 1'b1; clk_cycle(); sample_tick = 1'b0;
            vectors++;
            if (gains[1:0] !== GB'(exp0[k])) begin
                miscompares++; $display("FAIL retarget_ch0: step %0d got %b expected %b", k, gains[1:0], GB'(exp0[k]));
            end
            if (k == 0) begin
                cfg_valid = 1'b1; cfg_gain = 2'b01; clk_cycle(); cfg_valid = 1'b0;
            end
            clk_cycle();
        end
    endtask

    task automatic test_reset_mid_ramp();
        cfg_valid = 1'b1; cfg_all = 1'b1; cfg_gain = 2'b10; cfg_en = 1'b1;
        clk_cycle(); cfg_valid = 1'b0; clk_cycle();
        sample_tick = 1'b1; clk_cycle(); sample_tick = 1'b0;
        vectors++;
        if (gains !== model_gains()) begin miscompares++; $display("FAIL mid_ramp_gains: got %h expected %h", gains, model_gains()); end
        cfg_valid = 1'b1; cfg_all = 1'b0; cfg_ch = 4'd1; cfg_gain = 2'b00;
        clk_cycle(); cfg_valid = 1'b0;
        rst = 1'b1; clk_cycle(); rst = 1'b0;
        vectors += 4;
        if (gains !== 16'h5555) begin miscompares++; $display("FAIL rst_mid_gains: got %h expected 5555", gains); end
        if (amp_en !== 1'b0) begin miscompares++; $display("FAIL rst_mid_amp_en: got %b expected 0", amp_en); end
        if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_ready: got %b expected 1", cfg_ready); end
        if (settled !== 1'b1) begin miscompares++; $display("FAIL rst_mid_settled: got %b expected 1", settled); end
        for (int k = 0; k < 4; k++) begin
            sample_tick = 1'b1; clk_cycle(); sample_tick = 1'b0;
            vectors++;
            if (gains !== 16'h5555 || amp_en !== 1'b0) begin
                miscompares++; $display("FAIL pending_lost: got gains=%h amp_en=%b expected 5555/0", gains, amp_en);
            end
        end
        cfg_valid = 1'b1; cfg_all = 1'b0; cfg_ch = 4'd9; cfg_gain = 2'b10; cfg_en = 1'b1;
        clk_cycle(); cfg_valid = 1'b0; clk_cycle();
        sample_tick = 1'b1; clk_cycle(); sample_tick = 1'b0;
        vectors += 2;
        if (gains !== 16'h5555 || settled !== 1'b1) begin
            miscompares++; $display("FAIL ch9_dropped: got gains=%h settled=%b expected 5555/1", gains, settled);
        end
        if (amp_en !== 1'b1) begin miscompares++; $display("FAIL ch9_amp_en: got %b expected 1", amp_en); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            rst         = ($urandom_range(0, 63) == 0);
            sample_tick = ($urandom_range(0, 2) == 0);
            cfg_valid   = 1'($urandom);
            cfg_all     = ($urandom_range(0, 3) == 0);
            cfg_ch      = CB'($urandom_range(0, 11));
            cfg_gain    = GB'($urandom);
            cfg_en      = 1'($urandom);
            clk_cycle();
            vectors++;
            if (gains !== model_gains() || amp_en !== m_en || settled !== m_settled || cfg_ready !== m_ready) begin
                miscompares++;
                $display("FAIL random: cycle %0d got g=%h en=%b st=%b rdy=%b expected g=%h en=%b st=%b rdy=%b",
                         k, gains, amp_en, settled, cfg_ready, model_gains(), m_en, m_settled, m_ready);
            end
        end
        rst = 1'b0; sample_tick = 1'b0; cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_all_write();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid_ramp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gain_ramp_controller.md
Name: gain_ramp_controller

Overview:
Sequences the per-filter gain vector and enable that drive the filter-bank amplifier. Gain changes arrive from the control side (UART/register decoder) over a valid/ready handshake. Each channel's applied gain then ramps one LSB per sample tick toward its target, which avoids audible steps. Sits between the control decoder and the amplifier's gains/en inputs, in the sample-clock domain.

Parameters:
NUMBER_OF_FILTERS, 8, number of channels; must match the amplifier.
GAIN_BITS, 2, signed two's-complement width of each gain; must match the amplifier.
GAIN_FRAC_BITS, 0, fractional bits of the gain; the reset gain is unity = 1 << GAIN_FRAC_BITS.
CH_BITS, 3, channel index width; must satisfy 2**CH_BITS >= NUMBER_OF_FILTERS.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sample_tick  in  1  one-cycle strobe, once per audio sample
cfg_valid  in  1  gain write request
cfg_ready  out  1  controller can accept a request
cfg_all  in  1  1 = apply cfg_gain to every channel; cfg_ch ignored
cfg_ch  in  CH_BITS  target channel index
cfg_gain  in  GAIN_BITS  signed target gain
cfg_en  in  1  requested amplifier enable; sampled on handshake
gains  out  NUMBER_OF_FILTERS*GAIN_BITS  packed applied gains; channel i at [(i+1)*GAIN_BITS-1 : i*GAIN_BITS]
amp_en  out  1  amplifier enable
settled  out  1  every applied gain equals its target

Behaviour:
- Reset (rst=1 at a clk edge):
  - every target[i] and applied[i] = unity; amp_en = 0; settled = 1; cfg_ready = 1.
  - Pending request is discarded.
  - Reset mid-ramp aborts the ramp immediately.
- Handshake:
  - A request is accepted on a cycle where cfg_valid & cfg_ready.
  - Accepted fields are captured into a one-entry pending register; cfg_ready is 0 on the following cycle.
  - The cycle after acceptance is the commit cycle:
    - target[cfg_ch] = cfg_gain, or all targets if cfg_all;
    - amp_en_req = cfg_en;
    - pending clears, and cfg_ready returns to 1 the next cycle.
  - Maximum throughput: one request every 2 cycles.
  - cfg_ch >= NUMBER_OF_FILTERS with cfg_all=0: accepted and dropped (no target changes); cfg_en is still applied.
- Ramp:
  - On a sample_tick cycle, for each i:
    - if applied[i] < target[i] (signed compare), then applied[i] += 1;
    - if applied[i] > target[i], then applied[i] -= 1;
    - otherwise hold.
  - Overflow cannot occur because the ramp moves only toward an in-range target.
  - The outputs update on the clk edge that samples the tick, so gains changes one cycle after the tick cycle.
  - Tick and commit in the same cycle: the ramp step uses the pre-commit targets. The new target takes effect from the next tick.
  - A target rewritten mid-ramp makes the ramp continue from the current applied value toward the new target. Applied values never jump.
- Enable:
  - amp_en updates to amp_en_req only on a sample_tick cycle, so it changes on a sample boundary.
  - Gains keep ramping while amp_en = 0.
- settled:
  - Registered; equals 1 when applied[i] == target[i] for all i.
  - Evaluated on the post-update state, so it is valid the cycle after any commit or tick.
  - Goes 0 the cycle after a commit that creates a mismatch.
- All outputs are registered. There is no combinational path from cfg_* to gains or amp_en.

Decomposition:
- Shared package: unity-gain constant function (1 << GAIN_FRAC_BITS), signed min/max gain constants, and the packed-vector slice helper for channel i.
- The amplifier reuses the same package.
- One natural sub-module, gain_ramp_channel: holds target/applied for one channel and performs the step and compare. It has commit-write and tick inputs, and applied/equal outputs.
- The top level owns the handshake, the pending register, the enable, and the reduction of the equal flags into settled.

Test Plan:
- Reset then idle: gains = 16'h5555 (all unity = 2'b01), amp_en = 0, settled = 1, cfg_ready = 1; no change across 10 ticks.
- Write ch3 = -2 (2'b10), cfg_en = 1 -> cfg_ready 0 for 1 cycle; settled = 0. Ch3 goes 1 -> 0 -> -1 -> -2 on ticks 1, 2, 3; settled = 1 after tick 3; amp_en = 1 after tick 1.
- cfg_all = 1, cfg_gain = 0 -> every channel steps 1 -> 0 on the next tick; gains = 16'h0000; other channels untouched in a single-channel write test.
- Commit and tick in the same cycle -> no step on that tick; the first step occurs on the following tick.
- Back-to-back cfg_valid held high -> acceptances exactly every 2 cycles; last-written target wins. Retarget ch0 from -2 back to 1 mid-ramp reverses direction without a jump.
- Assert rst mid-ramp -> next cycle all gains unity, amp_en 0, pending request lost; cfg_ch = 9 with cfg_all = 0 changes no gains.
